// File: rtl/rv32i_pkg.sv
// Shared RV32I control encodings: immediate formats, opcodes, FSM states
// and datapath mux selects used by the multi-cycle controller.
package rv32i_pkg;

    typedef enum logic [2:0] {
        IMM_I     = 3'b000,
        IMM_S     = 3'b001,
        IMM_SHAMT = 3'b010,
        IMM_U     = 3'b011,
        IMM_B     = 3'b100,
        IMM_J     = 3'b101
    } extend_sel_e;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_ALU   = 2'd1;
    localparam logic [1:0] PC_JALR  = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory bundle; master = controller.
// Counter signals exist only when PERF_COUNTERS_EN is defined.
interface multicycle_controller_if
`ifdef PERF_COUNTERS_EN
    #(parameter int CNT_W = 32)
`endif
    ;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        branch_taken;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        alu_src_a;
    logic        alu_src_b;
    logic [2:0]  extend_sel;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        halted;
    logic [31:0] pc_init;
`ifdef PERF_COUNTERS_EN
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instret_cnt;
`endif

    modport master (
        input  mem_rdata, mem_ready, branch_taken,
        output mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel,
               alu_src_a, alu_src_b, extend_sel, reg_we, wb_sel,
               halted, pc_init
`ifdef PERF_COUNTERS_EN
        , cycle_cnt, instret_cnt
`endif
    );

    modport slave (
        output mem_rdata, mem_ready, branch_taken,
        input  mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel,
               alu_src_a, alu_src_b, extend_sel, reg_we, wb_sel,
               halted, pc_init
`ifdef PERF_COUNTERS_EN
        , cycle_cnt, instret_cnt
`endif
    );

endinterface

// File: rtl/multicycle_controller_imm_sel_decode.sv
// Combinational opcode/funct3 -> immediate format and illegal-opcode flag.
module imm_sel_decode
    import rv32i_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    output extend_sel_e extend_sel,
    output logic        illegal
);

    logic is_shift;
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    always_comb begin
        extend_sel = IMM_I;
        illegal    = 1'b0;
        unique case (1'b1)
            opcode == OPC_OP_IMM: extend_sel = is_shift ? IMM_SHAMT : IMM_I;
            opcode == OPC_LOAD:   extend_sel = IMM_I;
            opcode == OPC_JALR:   extend_sel = IMM_I;
            opcode == OPC_OP:     extend_sel = IMM_I;
            opcode == OPC_STORE:  extend_sel = IMM_S;
            opcode == OPC_LUI:    extend_sel = IMM_U;
            opcode == OPC_AUIPC:  extend_sel = IMM_U;
            opcode == OPC_BRANCH: extend_sel = IMM_B;
            opcode == OPC_JAL:    extend_sel = IMM_J;
            default:              illegal    = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM over shared memory and ALU.
// Define PERF_COUNTERS_EN to add cycle_cnt/instret_cnt outputs.
module multicycle_controller
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef PERF_COUNTERS_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic clk,
    input  logic rst_n,
    multicycle_controller_if.master bus
);

    localparam logic [2:0] S_FETCH  = ST_FETCH;
    localparam logic [2:0] S_DECODE = ST_DECODE;
    localparam logic [2:0] S_EXEC   = ST_EXEC;
    localparam logic [2:0] S_MEM    = ST_MEM;
    localparam logic [2:0] S_WB     = ST_WB;
    localparam logic [2:0] S_HALT   = ST_HALT;

    logic [2:0]  state, state_nxt;
    logic        started;
    logic [6:0]  opcode_q;
    logic [2:0]  funct3_q;
    extend_sel_e ext_q, dec_ext;
    logic        dec_illegal;
    logic [6:0]  dec_op;
    logic [2:0]  dec_f3;
    logic        fetch_done;

    // In FETCH decode the incoming word; afterwards the latched fields.
    assign dec_op = (state == S_FETCH) ? bus.mem_rdata[6:0] : opcode_q;
    assign dec_f3 = (state == S_FETCH) ? bus.mem_rdata[14:12] : funct3_q;

    imm_sel_decode u_dec (
        .opcode     (dec_op),
        .funct3     (dec_f3),
        .extend_sel (dec_ext),
        .illegal    (dec_illegal)
    );

    logic is_load, is_store, is_branch, is_jal, is_jalr;
    logic is_lui, is_auipc, is_op;
    assign is_load   = opcode_q == OPC_LOAD;
    assign is_store  = opcode_q == OPC_STORE;
    assign is_branch = opcode_q == OPC_BRANCH;
    assign is_jal    = opcode_q == OPC_JAL;
    assign is_jalr   = opcode_q == OPC_JALR;
    assign is_lui    = opcode_q == OPC_LUI;
    assign is_auipc  = opcode_q == OPC_AUIPC;
    assign is_op     = opcode_q == OPC_OP;

    // started keeps the first post-reset cycle quiet and drops
    // mem_req asynchronously with rst_n.
    assign fetch_done = (state == S_FETCH) && started && bus.mem_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  if (fetch_done) state_nxt = S_DECODE;
            S_DECODE: state_nxt = dec_illegal ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (is_branch)
                    state_nxt = S_FETCH;
                else if (is_load || is_store)
                    state_nxt = S_MEM;
                else
                    state_nxt = S_WB;
            end
            S_MEM:
                if (bus.mem_ready) state_nxt = is_store ? S_FETCH : S_WB;
            S_WB:     state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            started  <= 1'b0;
            opcode_q <= '0;
            funct3_q <= '0;
            ext_q    <= IMM_I;
        end else begin
            state   <= state_nxt;
            started <= 1'b1;
            if (fetch_done) begin
                opcode_q <= bus.mem_rdata[6:0];
                funct3_q <= bus.mem_rdata[14:12];
                ext_q    <= dec_ext;
            end
        end
    end

    always_comb begin
        bus.mem_req      = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_addr_sel = 1'b0;
        bus.ir_we        = 1'b0;
        bus.pc_we        = 1'b0;
        bus.pc_sel       = PC_PLUS4;
        bus.alu_src_a    = 1'b0;
        bus.alu_src_b    = 1'b0;
        bus.reg_we       = 1'b0;
        bus.wb_sel       = WB_ALU;
        case (state)
            S_FETCH: begin
                bus.mem_req = started;
                bus.ir_we   = fetch_done;
                bus.pc_we   = fetch_done;
            end
            S_EXEC: begin
                bus.alu_src_a = is_auipc || is_jal || is_branch;
                bus.alu_src_b = !is_op;
                if (is_branch) begin
                    bus.pc_sel = PC_ALU;
                    bus.pc_we  = bus.branch_taken;
                end
            end
            S_MEM: begin
                bus.mem_req      = 1'b1;
                bus.mem_addr_sel = 1'b1;
                bus.mem_we       = is_store;
            end
            S_WB: begin
                bus.reg_we = 1'b1;
                if (is_load)
                    bus.wb_sel = WB_MEM;
                else if (is_jal || is_jalr)
                    bus.wb_sel = WB_PC4;
                else if (is_lui)
                    bus.wb_sel = WB_IMM;
                bus.pc_we = is_jal || is_jalr;
                if (is_jal)
                    bus.pc_sel = PC_ALU;
                else if (is_jalr)
                    bus.pc_sel = PC_JALR;
            end
            default: ;
        endcase
    end

    assign bus.extend_sel = ext_q;
    assign bus.halted     = state == S_HALT;
    assign bus.pc_init    = RESET_PC;

`ifdef PERF_COUNTERS_EN
    logic retire;
    assign retire = (state_nxt == S_FETCH) &&
                    ((state == S_EXEC) || (state == S_MEM) || (state == S_WB));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.cycle_cnt   <= '0;
            bus.instret_cnt <= '0;
        end else begin
            if (state != S_HALT) bus.cycle_cnt <= bus.cycle_cnt + 1'b1;
            if (retire) bus.instret_cnt <= bus.instret_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: per-instruction cycle traces from an ISA-level model.
module tb_multicycle_controller;

    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111;
    localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111;
    localparam logic [6:0] BR = 7'b1100011, LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011, OPI = 7'b0010011;
    localparam logic [6:0] OP = 7'b0110011;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       alu_a;
        logic       alu_b;
        logic [2:0] ext;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic       halted;
    } outs_t;

    typedef struct {
        logic        ready;
        logic [31:0] rdata;
        logic        taken;
        outs_t       exp;
        logic        retire;
        int          want_ext;
        string       tag;
    } cyc_t;

    typedef struct {
        logic [31:0] word;
        int          fw;
        int          mw;
        logic        taken;
        int          ext;
        string       name;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_controller_if bus ();

    multicycle_controller #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    cyc_t q[$];
    logic [2:0] cur_ext;
    logic [31:0] exp_cyc, exp_ret;

    function automatic outs_t sample();
        outs_t s;
        s.mem_req      = bus.mem_req;
        s.mem_we       = bus.mem_we;
        s.mem_addr_sel = bus.mem_addr_sel;
        s.ir_we        = bus.ir_we;
        s.pc_we        = bus.pc_we;
        s.pc_sel       = bus.pc_sel;
        s.alu_a        = bus.alu_src_a;
        s.alu_b        = bus.alu_src_b;
        s.ext          = bus.extend_sel;
        s.reg_we       = bus.reg_we;
        s.wb_sel       = bus.wb_sel;
        s.halted       = bus.halted;
        return s;
    endfunction

    function automatic logic [2:0] spec_ext(logic [6:0] op, logic [2:0] f3);
        case (op)
            OPI:        return (f3 == 3'b001 || f3 == 3'b101) ? 3'b010 : 3'b000;
            ST:         return 3'b001;
            LUI, AUIPC: return 3'b011;
            BR:         return 3'b100;
            JAL:        return 3'b101;
            default:    return 3'b000;
        endcase
    endfunction

    function automatic void add(logic r, logic [31:0] d, logic t, outs_t o,
                                logic ret, int we, string tag);
        cyc_t c;
        c.ready = r; c.rdata = d; c.taken = t; c.exp = o;
        c.retire = ret; c.want_ext = we; c.tag = tag;
        q.push_back(c);
    endfunction

    task automatic check_outs(input outs_t exp, input string tag);
        outs_t act;
        act = sample();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s outs got=%h want=%h", tag, act, exp);
        end
`ifdef PERF_COUNTERS_EN
        checks++;
        if (bus.cycle_cnt !== exp_cyc || bus.instret_cnt !== exp_ret) begin
            errors++;
            $display("FAIL %s counters got=%0d/%0d want=%0d/%0d", tag,
                     bus.cycle_cnt, bus.instret_cnt, exp_cyc, exp_ret);
        end
`endif
    endtask

    task automatic step(input cyc_t c);
        bus.mem_ready    = c.ready;
        bus.mem_rdata    = c.rdata;
        bus.branch_taken = c.taken;
        @(negedge clk);
        check_outs(c.exp, c.tag);
        if (c.want_ext >= 0) begin
            checks++;
            if (bus.extend_sel !== c.want_ext[2:0]) begin
                errors++;
                $display("FAIL %s extend_sel got=%b want=%b", c.tag,
                         bus.extend_sel, c.want_ext[2:0]);
            end
        end
        if (!c.exp.halted) exp_cyc++;
        if (c.retire) exp_ret++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        while (q.size() > 0) step(q.pop_front());
    endtask

    // Builds the expected trace of one instruction from the ISA rules.
    task automatic build(input logic [31:0] w, input int fw, input int mw,
                         input logic tk, input int want_ext,
                         input string nm, output logic illegal);
        logic [6:0] op;
        outs_t o;
        op = w[6:0];
        illegal = !(op inside {LUI, AUIPC, JAL, JALR, BR, LD, ST, OPI, OP});
        for (int i = 0; i < fw; i++) begin
            o = '0; o.mem_req = 1'b1; o.ext = cur_ext;
            add(1'b0, $urandom, tk, o, 1'b0, -1, {nm, ":fwait"});
        end
        o = '0; o.mem_req = 1'b1; o.ir_we = 1'b1; o.pc_we = 1'b1;
        o.ext = cur_ext;
        add(1'b1, w, tk, o, 1'b0, -1, {nm, ":fetch"});
        cur_ext = spec_ext(op, w[14:12]);
        o = '0; o.ext = cur_ext;
        add(1'b0, $urandom, tk, o, 1'b0, want_ext, {nm, ":decode"});
        if (illegal) return;
        o = '0; o.ext = cur_ext;
        o.alu_a = op inside {AUIPC, JAL, BR};
        o.alu_b = op != OP;
        if (op == BR) begin
            o.pc_sel = 2'd1; o.pc_we = tk;
            add(1'b0, $urandom, tk, o, 1'b1, -1, {nm, ":exec"});
            return;
        end
        add(1'b0, $urandom, tk, o, 1'b0, -1, {nm, ":exec"});
        if (op == LD || op == ST) begin
            o = '0; o.ext = cur_ext; o.mem_req = 1'b1;
            o.mem_addr_sel = 1'b1; o.mem_we = op == ST;
            for (int i = 0; i < mw; i++)
                add(1'b0, $urandom, tk, o, 1'b0, -1, {nm, ":mwait"});
            add(1'b1, $urandom, tk, o, op == ST, -1, {nm, ":mem"});
            if (op == ST) return;
        end
        o = '0; o.ext = cur_ext; o.reg_we = 1'b1;
        case (op)
            LD:       o.wb_sel = 2'd1;
            JAL:      begin o.wb_sel = 2'd2; o.pc_we = 1'b1; o.pc_sel = 2'd1; end
            JALR:     begin o.wb_sel = 2'd2; o.pc_we = 1'b1; o.pc_sel = 2'd2; end
            LUI:      o.wb_sel = 2'd3;
            default:  o.wb_sel = 2'd0;
        endcase
        add(1'b0, $urandom, tk, o, 1'b1, -1, {nm, ":wb"});
    endtask

    task automatic release_reset();
        outs_t o;
        rst_n = 1'b1;
        cur_ext = 3'b000;
        exp_cyc = '0;
        exp_ret = '0;
        o = '0;
        add(1'b1, 32'h00500093, 1'b0, o, 1'b0, -1, "post_reset_idle");
        drain();
    endtask

    vec_t vecs[14];
    logic [6:0] ops[9];

    initial begin
        logic ill;
        logic [31:0] r;
        outs_t z;
        vecs[0]  = '{32'h00500093, 0, 0, 1'b0, 0, "addi"};
        vecs[1]  = '{32'h00209093, 0, 0, 1'b0, 2, "slli"};
        vecs[2]  = '{32'h4020D093, 1, 0, 1'b0, 2, "srai"};
        vecs[3]  = '{32'h0011A023, 0, 0, 1'b0, 1, "sw"};
        vecs[4]  = '{32'h0000A103, 0, 3, 1'b0, 0, "lw_wait3"};
        vecs[5]  = '{32'h00000463, 0, 0, 1'b1, 4, "beq_taken"};
        vecs[6]  = '{32'h00000463, 0, 0, 1'b0, 4, "beq_not"};
        vecs[7]  = '{32'h008000EF, 0, 0, 1'b0, 5, "jal"};
        vecs[8]  = '{32'h000080E7, 0, 0, 1'b1, 0, "jalr"};
        vecs[9]  = '{32'h000012B7, 0, 0, 1'b0, 3, "lui"};
        vecs[10] = '{32'h00001297, 0, 0, 1'b0, 3, "auipc"};
        vecs[11] = '{32'h002081B3, 0, 0, 1'b1, 0, "add"};
        vecs[12] = '{32'h00500093, 2, 0, 1'b0, 0, "addi_fwait2"};
        vecs[13] = '{32'h0011A023, 1, 2, 1'b1, 1, "sw_waits"};
        ops = '{LUI, AUIPC, JAL, JALR, BR, LD, ST, OPI, OP};

        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        bus.branch_taken = 1'b0;
        exp_cyc = '0;
        exp_ret = '0;
        repeat (3) @(posedge clk);
        #1;
        bus.mem_ready = 1'b1;
        #1;
        z = '0;
        check_outs(z, "in_reset");
        checks++;
        if (bus.pc_init !== 32'h0000_0000) begin
            errors++;
            $display("FAIL pc_init got=%h want=%h", bus.pc_init, 32'h0);
        end
        @(posedge clk);
        #1;
        release_reset();

        foreach (vecs[i]) begin
            build(vecs[i].word, vecs[i].fw, vecs[i].mw, vecs[i].taken,
                  vecs[i].ext, vecs[i].name, ill);
            drain();
        end

        for (int n = 0; n < 40; n++) begin
            r = $urandom;
            build({r[31:7], ops[$urandom_range(0, 8)]}, $urandom_range(0, 2),
                  $urandom_range(0, 2), 1'($urandom_range(0, 1)), -1,
                  $sformatf("rnd%0d", n), ill);
            drain();
        end

        build(32'hFFFFFFFF, 0, 0, 1'b0, 0, "illegal", ill);
        z = '0; z.halted = 1'b1; z.ext = cur_ext;
        for (int i = 0; i < 5; i++)
            add(1'($urandom_range(0, 1)), 32'h00500093, 1'b1, z, 1'b0, -1,
                "halt_hold");
        drain();
        rst_n = 1'b0;
        #1;
        z = '0;
        check_outs(z, "halt_reset");
        @(posedge clk);
        #1;
        release_reset();
        build(32'h00500093, 0, 0, 1'b0, 0, "addi_after_halt", ill);
        drain();

        build(32'h00500093, 2, 0, 1'b0, -1, "fwait_pre", ill);
        q.delete();
        z = '0; z.mem_req = 1'b1; z.ext = cur_ext;
        add(1'b0, 32'h0, 1'b0, z, 1'b0, -1, "fwait_before_rst");
        drain();
        bus.mem_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        z = '0;
        exp_cyc = '0;
        exp_ret = '0;
        check_outs(z, "rst_mid_fetch");
        @(posedge clk);
        #1;
        release_reset();
        build(32'h008000EF, 0, 0, 1'b0, 5, "jal_after_rst", ill);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
